bcd_ndigit: RTL

BCD_NDIGIT -- requirements
Module: bcd_ndigit

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd_ndigit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the N-digit binary-to-BCD converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;

   // Largest value representable in n decimal digits (10^n - 1).
   function automatic logic [63:0] bcd_max(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r - 64'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Double-dabble correction for one BCD digit (add 3 when >= 5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_ndigit.sv
// ============================================================================
// Module   : bcd_ndigit
// Brief    : Sequential double-dabble binary-to-BCD converter, one bit per cycle,
//            with saturating overflow. Optional macro BCD_NDIGIT_BLANK_EN adds
//            a leading-zero blank mask output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_ndigit #(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done,
   output logic                  busy,
   output logic                  overflow
`ifdef BCD_NDIGIT_BLANK_EN
  ,output logic [DIGITS-1:0]     blank
`endif
);

   import bcd_pkg::*;

   localparam int              c_aw     = BCD_DIGIT_W * DIGITS;
   localparam int              c_cw     = $clog2(WIDTH + 1);
   localparam logic [c_cw-1:0] c_last   = c_cw'(WIDTH - 1);
   localparam logic [63:0]     c_max    = bcd_max(DIGITS);
   localparam logic [63:0]     c_in_max = (64'd1 << WIDTH) - 64'd1;

   state_t             r_state;
   logic [WIDTH-1:0]   r_sreg;
   logic [c_aw-1:0]    r_acc;
   logic [c_cw-1:0]    r_cnt;
   logic               r_ovf;

   logic [c_aw-1:0]    w_adj;
   logic [c_aw-1:0]    w_acc_next;
   logic [c_aw-1:0]    w_result;
   logic               w_ovf;
   logic               w_accept;
   logic               w_finish;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_adj
         bcd_digit_adj u_adj (
            .i_digit (r_acc[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end

      // When every input value fits in DIGITS digits the comparator is dropped.
      if (c_max >= c_in_max) begin : g_ovf_never
         assign w_ovf = 1'b0;
      end else begin : g_ovf_cmp
         assign w_ovf = (64'(value) > c_max);
      end
   endgenerate

   // Corrected digits shift left, the binary MSB enters at bit 0; the top bit is dropped.
   assign w_acc_next = (w_adj << 1) | c_aw'(r_sreg[WIDTH-1]);
   assign w_result   = r_ovf ? {DIGITS{4'h9}} : w_acc_next;
   assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_finish   = (r_state == SHIFT) && (r_cnt == c_last);

   assign done = (r_state == DONE);
   assign busy = (r_state == SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_sreg   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_sreg  <= value;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= w_ovf;
                  r_state <= SHIFT;
               end else begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               r_acc  <= w_acc_next;
               r_sreg <= r_sreg << 1;
               r_cnt  <= r_cnt + c_cw'(1);
               if (w_finish) begin
                  r_state  <= DONE;
                  bcd      <= w_result;
                  overflow <= r_ovf;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef BCD_NDIGIT_BLANK_EN
   logic [DIGITS-1:0] w_blank;
   logic              w_zero_run;

   // Walk from the top digit down; digit 0 is always shown.
   always_comb begin
      w_blank    = '0;
      w_zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_run = w_zero_run && (w_result[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
         w_blank[i] = w_zero_run;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank <= '0;
      end else if (w_finish) begin
         blank <= w_blank;
      end
   end
`endif

endmodule

`default_nettype wire
